// File: rtl/rtc_saver_pkg.sv
// Shared constants and types for the RTC snapshot saver and the RTC loader.
// Both sides agree on the word count and the word width kept here.
package rtc_saver_pkg;
    localparam int RTC_WORDS_DEFAULT = 10;
    localparam int RTC_WORD_W        = 16;

    // Loader side: a restored image carries this many words behind a magic tag
    localparam int          RTC_LOAD_WORDS = RTC_WORDS_DEFAULT;
    localparam logic [15:0] RTC_LOAD_MAGIC = 16'h5254;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        WRITE,
        INC,
        DONE
    } saver_state_t;
endpackage

// File: rtl/rtc_saver_if.sv
// Core-side RTC read port and host-side snapshot readout port of the saver.
interface rtc_saver_if #(
    parameter int AW = 5
);
    // core_rd is a one-cycle strobe with core_addr stable; the core answers
    // on core_data one cycle later and holds it. rd_data follows rd_addr by one cycle.
    logic [AW-1:0] core_addr;
    logic          core_rd;
    logic [15:0]   core_data;
    logic [AW-1:0] rd_addr;
    logic [15:0]   rd_data;

    modport master (
        output core_addr,
        output core_rd,
        output rd_data,
        input  core_data,
        input  rd_addr
    );

    modport slave (
        input  core_addr,
        input  core_rd,
        input  rd_data,
        output core_data,
        output rd_addr
    );
endinterface

// File: rtl/rtc_saver_ram.sv
// Simple dual-port snapshot RAM: one write port, one registered read port.
module rtc_ram #(
    parameter int AW = 5,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/rtc_saver.sv
// Captures RTC_WORDS words from the core into a snapshot RAM on a host save
// request, tracking whether the RTC has changed since the last snapshot.
module rtc_saver
    import rtc_saver_pkg::*;
#(
    parameter int RTC_WORDS = RTC_WORDS_DEFAULT,
    parameter int AW        = 5
) (
    input  logic         clk_sys,
    input  logic         reset,
    input  logic         cart_download,
    input  logic         save_req,
    input  logic         rtc_change,
    rtc_saver_if.master  bus,
    output logic         busy,
    output logic         save_done,
    output logic         dirty,
    output saver_state_t fsm_state
);
    saver_state_t  state;
    saver_state_t  state_next;
    logic [AW-1:0] counter;
    logic [AW:0]   cnt_inc;
    logic          save_req_q;
    logic          armed;
    logic          save_rise;
    logic          start;
    logic          ram_we;

    // armed stays low while save_req is held high across reset release,
    // so only a fresh rising edge after reset can start a save
    assign save_rise = save_req & ~save_req_q & armed;
    assign start     = (state == IDLE) & save_rise;
    assign cnt_inc   = {1'b0, counter} + 1'b1;
    assign fsm_state = state;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            save_req_q <= 1'b0;
            armed      <= ~save_req;
        end else begin
            save_req_q <= save_req;
            if (!save_req) begin
                armed <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = REQ;
            REQ:     state_next = WAIT;
            WAIT:    state_next = WRITE;
            WRITE:   state_next = INC;
            INC:     state_next = (cnt_inc < (AW+1)'(RTC_WORDS)) ? REQ : DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.core_rd   = 1'b0;
        bus.core_addr = counter;
        busy          = 1'b1;
        ram_we        = 1'b0;
        case (state)
            IDLE: begin
                bus.core_addr = '0;
                busy          = 1'b0;
            end
            REQ:     bus.core_rd = 1'b1;
            WRITE:   ram_we = ~reset;
            DONE:    bus.core_addr = '0;
            default: ;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            counter <= '0;
        end else if (state == INC) begin
            counter <= cnt_inc[AW-1:0];
        end else if (state == DONE) begin
            counter <= '0;
        end
    end

    // A change reported on the very cycle the snapshot starts must survive
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            dirty <= 1'b0;
        end else if (rtc_change) begin
            dirty <= 1'b1;
        end else if (start || cart_download) begin
            dirty <= 1'b0;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            save_done <= 1'b0;
        end else if (start || cart_download) begin
            save_done <= 1'b0;
        end else if (state_next == DONE) begin
            save_done <= 1'b1;
        end
    end

    rtc_ram #(
        .AW (AW),
        .DW (RTC_WORD_W)
    ) u_ram (
        .clk   (clk_sys),
        .we    (ram_we),
        .waddr (counter),
        .wdata (bus.core_data),
        .raddr (bus.rd_addr),
        .rdata (bus.rd_data)
    );
endmodule

// File: tb/tb_rtc_saver.sv
// Bench for rtc_saver: behavioural core model, strobe and readout scoreboards,
// directed save scenarios with hand-computed buffer contents.
module tb_rtc_saver;
    import rtc_saver_pkg::*;

    localparam int AW = 5;
    localparam int W  = 10;
    localparam int NO = -9;

    logic         clk_sys = 1'b0;
    logic         reset;
    logic         cart_download;
    logic         save_req;
    logic         rtc_change;
    logic         busy;
    logic         save_done;
    logic         dirty;
    saver_state_t fsm_state;

    rtc_saver_if #(.AW(AW)) bus();

    rtc_saver #(
        .RTC_WORDS (W),
        .AW        (AW)
    ) dut (
        .clk_sys       (clk_sys),
        .reset         (reset),
        .cart_download (cart_download),
        .save_req      (save_req),
        .rtc_change    (rtc_change),
        .bus           (bus),
        .busy          (busy),
        .save_done     (save_done),
        .dirty         (dirty),
        .fsm_state     (fsm_state)
    );

    always #5 clk_sys = ~clk_sys;

    // Core model: word k reads back as core_base + k, held until the next strobe
    logic [15:0] core_base;
    always @(posedge clk_sys) begin
        if (reset) bus.core_data <= 16'h0;
        else if (bus.core_rd) bus.core_data <= core_base + 16'(bus.core_addr);
    end

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_strobe = -1;
    int strobes = 0;
    logic [AW-1:0] exp_addr_q[$];
    logic [15:0]   exp_rd_q[$];
    logic [15:0]   exp_buf[W];
    logic          rd_issue = 1'b0;
    logic          rd_pend = 1'b0;

    always @(posedge clk_sys) begin
        cyc     <= cyc + 1;
        rd_pend <= rd_issue;
    end

    always @(negedge clk_sys) begin
        if (bus.core_rd) begin
            strobes++;
            checks++;
            if (exp_addr_q.size() == 0) begin
                errors++;
                $display("FAIL core_rd_extra: strobe at addr=%0d, none expected", bus.core_addr);
            end else begin
                logic [AW-1:0] ea;
                ea = exp_addr_q.pop_front();
                if (bus.core_addr !== ea) begin
                    errors++;
                    $display("FAIL core_addr: got %0d expected %0d", bus.core_addr, ea);
                end
                if (ea != 0) begin
                    checks++;
                    if (cyc - last_strobe != 4) begin
                        errors++;
                        $display("FAIL strobe_spacing: got %0d cycles expected 4", cyc - last_strobe);
                    end
                end
            end
            last_strobe = cyc;
        end
        if (rd_pend) begin
            checks++;
            if (exp_rd_q.size() == 0) begin
                errors++;
                $display("FAIL rd_data_extra: got %h with none expected", bus.rd_data);
            end else begin
                logic [15:0] ed;
                ed = exp_rd_q.pop_front();
                if (bus.rd_data !== ed) begin
                    errors++;
                    $display("FAIL rd_data: got %h expected %h", bus.rd_data, ed);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic push_addrs(input int n);
        for (int k = 0; k < n; k++) exp_addr_q.push_back(AW'(k));
    endtask

    // rtc_at = -1 pulses rtc_change together with the save_req edge
    task automatic run_save(input int rtc_at, input int glitch_at, input int cart_at,
                            input int rst_at, output int ncyc);
        save_req = 1'b1;
        if (rtc_at == -1) rtc_change = 1'b1;
        step();
        save_req   = 1'b0;
        rtc_change = 1'b0;
        check("busy_at_first_req", 32'(busy), 32'd1);
        check("core_rd_at_first_req", 32'(bus.core_rd), 32'd1);
        check("save_done_clear_on_start", 32'(save_done), 32'd0);
        check("dirty_at_first_req", 32'(dirty), (rtc_at == -1) ? 32'd1 : 32'd0);
        ncyc = 0;
        while (busy && ncyc < 100) begin
            if (ncyc == rtc_at) rtc_change = 1'b1;
            if (ncyc == glitch_at) save_req = 1'b1;
            if (ncyc == cart_at || ncyc == cart_at + 1) cart_download = 1'b1;
            if (ncyc == rst_at) reset = 1'b1;
            ncyc++;
            step();
            rtc_change    = 1'b0;
            save_req      = 1'b0;
            cart_download = 1'b0;
            reset         = 1'b0;
        end
    endtask

    task automatic read_back();
        for (int k = 0; k < W; k++) begin
            bus.rd_addr = AW'(k);
            exp_rd_q.push_back(exp_buf[k]);
            rd_issue = 1'b1;
            step();
        end
        rd_issue = 1'b0;
        step();
        step();
        check("rd_queue_drained", 32'(exp_rd_q.size()), 32'd0);
    endtask

    task automatic fill_exp(input logic [15:0] base, input int n);
        for (int k = 0; k < n; k++) exp_buf[k] = base + 16'(k);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_core_rd"}, 32'(bus.core_rd), 32'd0);
        check({tag, "_core_addr"}, 32'(bus.core_addr), 32'd0);
        check({tag, "_state"}, 32'(fsm_state), 32'(IDLE));
    endtask

    initial begin
        int n;
        int busy_seen;
        int s0;
        reset         = 1'b1;
        cart_download = 1'b0;
        save_req      = 1'b0;
        rtc_change    = 1'b0;
        core_base     = 16'h1000;
        bus.rd_addr   = '0;
        repeat (3) step();
        check_idle_outputs("reset");
        check("reset_save_done", 32'(save_done), 32'd0);
        check("reset_dirty", 32'(dirty), 32'd0);
        reset = 1'b0;
        step();

        // Basic save; dirty set beforehand must clear with no change during the save
        rtc_change = 1'b1;
        step();
        rtc_change = 1'b0;
        check("dirty_set", 32'(dirty), 32'd1);
        push_addrs(W);
        run_save(NO, NO, NO, NO, n);
        check("save1_cycles", 32'(n), 32'd41);
        check("save1_done", 32'(save_done), 32'd1);
        check("save1_dirty", 32'(dirty), 32'd0);
        check("save1_strobes_left", 32'(exp_addr_q.size()), 32'd0);
        check_idle_outputs("save1");
        fill_exp(16'h1000, W);
        read_back();

        // Ignored edge mid-save plus rtc_change on the first REQ cycle
        core_base = 16'h1100;
        s0 = strobes;
        push_addrs(W);
        run_save(0, 10, NO, NO, n);
        check("save2_cycles", 32'(n), 32'd41);
        check("save2_done", 32'(save_done), 32'd1);
        check("save2_dirty", 32'(dirty), 32'd1);
        busy_seen = 0;
        for (int i = 0; i < 50; i++) begin
            if (busy) busy_seen++;
            step();
        end
        check("save2_no_queued_save", 32'(busy_seen), 32'd0);
        check("save2_strobe_count", 32'(strobes - s0), 32'd10);
        check("save2_done_held", 32'(save_done), 32'd1);
        fill_exp(16'h1100, W);
        read_back();

        // rtc_change coincident with the clearing cycle: set wins
        core_base = 16'h1200;
        push_addrs(W);
        run_save(-1, NO, NO, NO, n);
        check("save3_cycles", 32'(n), 32'd41);
        check("save3_dirty", 32'(dirty), 32'd1);
        fill_exp(16'h1200, W);

        // cart_download mid-save clears flags but the save runs to completion
        core_base = 16'h1300;
        push_addrs(W);
        run_save(5, NO, 12, NO, n);
        check("save4_cycles", 32'(n), 32'd41);
        check("save4_done", 32'(save_done), 32'd1);
        check("save4_dirty", 32'(dirty), 32'd0);
        fill_exp(16'h1300, W);
        read_back();
        cart_download = 1'b1;
        step();
        cart_download = 1'b0;
        check("cart_clears_done", 32'(save_done), 32'd0);

        // Reset during word 5 WRITE: words 0..4 new, 5..9 keep previous values
        core_base = 16'h2000;
        push_addrs(6);
        run_save(15, NO, NO, 22, n);
        check("abort_cycles", 32'(n), 32'd23);
        check_idle_outputs("abort");
        check("abort_save_done", 32'(save_done), 32'd0);
        check("abort_dirty", 32'(dirty), 32'd0);
        check("abort_strobes_left", 32'(exp_addr_q.size()), 32'd0);
        fill_exp(16'h2000, 5);
        read_back();

        // save_req held high through reset release must not start a save
        save_req = 1'b1;
        reset    = 1'b1;
        step();
        step();
        reset = 1'b0;
        busy_seen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (busy) busy_seen++;
        end
        check("held_req_no_start", 32'(busy_seen), 32'd0);
        save_req = 1'b0;
        step();

        core_base = 16'h3000;
        push_addrs(W);
        run_save(NO, NO, NO, NO, n);
        check("save5_cycles", 32'(n), 32'd41);
        check("save5_done", 32'(save_done), 32'd1);
        fill_exp(16'h3000, W);
        read_back();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
